// File: rtl/timer_ctrl.sv
// Sequencing controller for the hh:mm:ss countdown datapath.
// Decodes keypad digit entry, gates the 1 Hz tick, handles pause and alarm.
module timer_ctrl #(
  parameter int CLK_HZ    = 1000,
  parameter int ALARM_SEC = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       dip_sw,
  input  logic [9:0] keypad,
  input  logic       cnt_zero,
  output logic       cnt_clr,
  output logic       wr_en,
  output logic [2:0] wr_idx,
  output logic [3:0] wr_val,
  output logic       tick,
  output logic       alarm,
  output logic       blink,
  output logic [2:0] state
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int SW = (ALARM_SEC > 0) ? $clog2(ALARM_SEC + 1) : 1;
  localparam logic [PW-1:0] TERM    = PW'(CLK_HZ - 1);
  localparam logic [PW-1:0] HALF_M1 = PW'(CLK_HZ / 2 - 1);
  localparam logic [SW-1:0] SEC_LST = SW'(ALARM_SEC - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ENTRY = 3'd1,
    S_ARMED = 3'd2,
    S_RUN   = 3'd3,
    S_PAUSE = 3'd4,
    S_ALARM = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic [9:0]    kp_prev_q, kp_prev_d;
  logic [2:0]    entry_q, entry_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [SW-1:0] sec_q, sec_d;
  logic          clr_q, clr_d;
  logic          wr_en_q, wr_en_d;
  logic [2:0]    idx_q, idx_d;
  logic [3:0]    val_q, val_d;
  logic          tick_q, tick_d;
  logic          alarm_q, alarm_d;
  logic          blink_q, blink_d;

  logic          one_hot;
  logic          kp_edge;
  logic [3:0]    key_idx;
  logic          p_term;
  logic [PW-1:0] p_nxt;

  always_comb begin
    key_idx = '0;
    for (int i = 0; i < 10; i++) begin
      if (keypad[i]) key_idx = 4'(i);
    end
  end

  assign one_hot = (keypad != '0) &&
                   ((keypad & (keypad - 10'd1)) == '0);
  assign kp_edge = one_hot && (kp_prev_q == '0);
  assign p_term  = (presc_q == TERM);
  assign p_nxt   = p_term ? '0 : presc_q + PW'(1);

  always_comb begin
    state_d   = state_q;
    kp_prev_d = keypad;
    entry_d   = entry_q;
    presc_d   = presc_q;
    sec_d     = sec_q;
    clr_d     = 1'b0;
    wr_en_d   = 1'b0;
    idx_d     = '0;
    val_d     = '0;
    tick_d    = 1'b0;
    blink_d   = blink_q;
    unique case (state_q)
      S_IDLE: begin
        if (dip_sw) begin
          state_d = S_ENTRY;
          clr_d   = 1'b1;
          entry_d = '0;
        end
      end
      S_ENTRY: begin
        if (!dip_sw) begin
          state_d = S_IDLE;
          clr_d   = 1'b1;
          entry_d = '0;
        end else if (kp_edge) begin
          wr_en_d = 1'b1;
          idx_d   = entry_q;
          val_d   = key_idx;
          if (entry_q == 3'd5) begin
            entry_d = '0;
            state_d = S_ARMED;
          end else begin
            entry_d = entry_q + 3'd1;
          end
        end
      end
      S_ARMED: begin
        if (!dip_sw) begin
          state_d = S_RUN;
          presc_d = '0;
        end
      end
      S_RUN: begin
        // the terminal tick is never lost to a pause request
        if (p_term) begin
          presc_d = '0;
          if (cnt_zero) begin
            state_d = S_ALARM;
            sec_d   = '0;
          end else begin
            tick_d = 1'b1;
            if (dip_sw) state_d = S_PAUSE;
          end
        end else if (dip_sw) begin
          state_d = S_PAUSE;
        end else begin
          presc_d = p_nxt;
        end
      end
      S_PAUSE: begin
        if (!dip_sw) begin
          state_d = S_RUN;
        end else if (kp_edge) begin
          state_d = S_ENTRY;
          clr_d   = 1'b1;
          entry_d = '0;
        end
      end
      S_ALARM: begin
        presc_d = p_nxt;
        if (kp_edge || dip_sw) begin
          state_d = S_IDLE;
        end else begin
          if (presc_q == HALF_M1 || p_term) blink_d = ~blink_q;
          if (p_term) begin
            if (sec_q == SEC_LST) state_d = S_IDLE;
            else sec_d = sec_q + SW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    alarm_d = (state_d == S_ALARM);
    if (state_d != S_ALARM) blink_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      kp_prev_q <= '0;
      entry_q   <= '0;
      presc_q   <= '0;
      sec_q     <= '0;
      clr_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      idx_q     <= '0;
      val_q     <= '0;
      tick_q    <= 1'b0;
      alarm_q   <= 1'b0;
      blink_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      kp_prev_q <= kp_prev_d;
      entry_q   <= entry_d;
      presc_q   <= presc_d;
      sec_q     <= sec_d;
      clr_q     <= clr_d;
      wr_en_q   <= wr_en_d;
      idx_q     <= idx_d;
      val_q     <= val_d;
      tick_q    <= tick_d;
      alarm_q   <= alarm_d;
      blink_q   <= blink_d;
    end
  end

  assign cnt_clr = clr_q;
  assign wr_en   = wr_en_q;
  assign wr_idx  = idx_q;
  assign wr_val  = val_q;
  assign tick    = tick_q;
  assign alarm   = alarm_q;
  assign blink   = blink_q;
  assign state   = state_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Scoreboard bench for timer_ctrl with CLK_HZ=10, ALARM_SEC=2.
// Strobes are matched against a queue of expected events.
module tb_timer_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       dip_sw = 1'b0;
  logic [9:0] keypad = '0;
  logic       cnt_zero = 1'b0;
  logic       cnt_clr, wr_en, tick, alarm, blink;
  logic [2:0] wr_idx, state;
  logic [3:0] wr_val;

  timer_ctrl #(.CLK_HZ(10), .ALARM_SEC(2)) dut (
    .clk(clk), .rst_n(rst_n), .dip_sw(dip_sw),
    .keypad(keypad), .cnt_zero(cnt_zero),
    .cnt_clr(cnt_clr), .wr_en(wr_en),
    .wr_idx(wr_idx), .wr_val(wr_val),
    .tick(tick), .alarm(alarm), .blink(blink),
    .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       kind;
    int       idx;
    int       val;
  } exp_t;

  localparam int K_CLR = 0;
  localparam int K_WR  = 1;
  localparam int K_TCK = 2;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic push(input int k, input int i, input int v);
    exp_t e;
    e.kind = k; e.idx = i; e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, act, req);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && (cnt_clr || wr_en || tick)) begin
      int   ak;
      exp_t e;
      int   ok;
      ak = (int'(cnt_clr) + int'(wr_en) + int'(tick) > 1) ? 3 :
           cnt_clr ? K_CLR : wr_en ? K_WR : K_TCK;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got kind=%0d idx=%0d val=%0d want none",
                 ak, wr_idx, wr_val);
      end else begin
        e = exp_q.pop_front();
        ok = (ak == e.kind);
        if (ak == K_WR)
          ok = ok && (int'(wr_idx) == e.idx) && (int'(wr_val) == e.val);
        if (!ok) begin
          errors++;
          $display("FAIL sb_event: got kind=%0d idx=%0d val=%0d want kind=%0d idx=%0d val=%0d",
                   ak, wr_idx, wr_val, e.kind, e.idx, e.val);
        end
      end
    end
  end

  task automatic press(input int k, input int hold);
    keypad = 10'd1 << k;
    cyc(hold);
    keypad = '0;
    cyc(1);
  endtask

  task automatic load(input int d0, input int d1, input int d2,
                      input int d3, input int d4, input int d5);
    int d[6];
    d = '{d0, d1, d2, d3, d4, d5};
    dip_sw = 1'b1;
    push(K_CLR, 0, 0);
    cyc(1);
    for (int i = 0; i < 6; i++) begin
      push(K_WR, i, d[i]);
      press(d[i], 2);
    end
    chk("load_armed", state, 2);
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      cyc(1);
      n++;
    end while (!tick && n < 40);
  endtask

  task automatic wait_alarm(output int n);
    n = 0;
    do begin
      cyc(1);
      n++;
    end while (state != 3'd5 && n < 40);
  endtask

  function automatic int outs();
    return int'({state, alarm, blink, tick, wr_en, cnt_clr, wr_idx, wr_val});
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int cnt;
    cyc(3);
    chk("reset_outs", outs(), 0);
    rst_n = 1'b1;
    cyc(2);
    chk("post_reset_state", state, 0);

    // 1) entry of 1..6
    push(K_CLR, 0, 0);
    dip_sw = 1'b1;
    cyc(1);
    chk("t1_entry", state, 1);
    chk("t1_clr", cnt_clr, 1);
    for (int k = 1; k <= 6; k++) begin
      push(K_WR, k - 1, k);
      press(k, 3);
    end
    chk("t1_armed", state, 2);
    press(9, 2);
    chk("t1_armed_ignores_key", state, 2);

    // 2) run and alarm
    dip_sw = 1'b0;
    cyc(1);
    chk("t2_run", state, 3);
    for (int p = 0; p < 3; p++) begin
      push(K_TCK, 0, 0);
      wait_tick(n);
      chk("t2_tick_period", n, 10);
    end
    cnt_zero = 1'b1;
    wait_alarm(n);
    chk("t2_alarm_delay", n, 10);
    chk("t2_alarm_hi", alarm, 1);
    chk("t2_blink_lo", blink, 0);

    // 3) alarm timeout and blink
    cnt_zero = 1'b0;
    for (int j = 1; j <= 20; j++) begin
      cyc(1);
      if (j == 4)  chk("t3_blink4", blink, 0);
      if (j == 5)  chk("t3_blink5", blink, 1);
      if (j == 10) chk("t3_blink10", blink, 0);
      if (j == 15) chk("t3_blink15", blink, 1);
      if (j == 19) chk("t3_state19", state, 5);
      if (j == 20) chk("t3_exit", {state, alarm, blink}, 0);
    end
    load(0, 0, 0, 0, 0, 1);
    cnt_zero = 1'b1;
    dip_sw = 1'b0;
    cyc(1);
    wait_alarm(n);
    chk("t3_alarm2_delay", n, 10);
    cyc(7);
    keypad = 10'd1;
    cyc(1);
    chk("t3_ack", {state, alarm, blink}, 0);
    keypad = '0;
    cnt_zero = 1'b0;
    cyc(1);

    // 4) pause and resume
    load(0, 0, 1, 0, 0, 0);
    dip_sw = 1'b0;
    cyc(1);
    chk("t4_run", state, 3);
    cyc(4);
    dip_sw = 1'b1;
    cyc(1);
    chk("t4_pause", state, 4);
    cnt = 0;
    for (int j = 0; j < 50; j++) begin
      cyc(1);
      cnt += int'(tick);
    end
    chk("t4_no_tick_paused", cnt, 0);
    push(K_TCK, 0, 0);
    dip_sw = 1'b0;
    cyc(1);
    chk("t4_resume", state, 3);
    wait_tick(n);
    chk("t4_resume_tick", n, 6);
    cyc(9);
    dip_sw = 1'b1;
    push(K_TCK, 0, 0);
    cyc(1);
    chk("t4_term_tick", tick, 1);
    chk("t4_term_pause", state, 4);
    push(K_CLR, 0, 0);
    keypad = 10'd1 << 3;
    cyc(1);
    chk("t4_pause_key_entry", state, 1);
    keypad = '0;
    cyc(1);

    // 5) multi-bit and held keys, abort
    keypad = 10'b0000000110;
    cyc(2);
    keypad = '0;
    cyc(1);
    chk("t5_multi_state", state, 1);
    push(K_WR, 0, 7);
    keypad = 10'd1 << 7;
    cnt = 0;
    for (int j = 0; j < 40; j++) begin
      cyc(1);
      cnt += int'(wr_en);
    end
    chk("t5_held_once", cnt, 1);
    keypad = '0;
    cyc(1);
    push(K_WR, 1, 2);
    press(2, 2);
    push(K_WR, 2, 5);
    press(5, 2);
    push(K_CLR, 0, 0);
    dip_sw = 1'b0;
    cyc(1);
    chk("t5_abort_idle", state, 0);
    chk("t5_abort_clr", cnt_clr, 1);
    cyc(1);

    // 6) async reset mid-RUN and mid-ENTRY
    load(9, 8, 7, 6, 5, 4);
    dip_sw = 1'b0;
    cyc(1);
    cyc(5);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_run", outs(), 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(2);
    chk("t6_after_rel", state, 0);
    dip_sw = 1'b1;
    push(K_CLR, 0, 0);
    cyc(1);
    push(K_WR, 0, 1);
    press(1, 2);
    push(K_WR, 1, 2);
    press(2, 2);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_entry", outs(), 0);
    cyc(2);
    push(K_CLR, 0, 0);
    rst_n = 1'b1;
    cyc(1);
    chk("t6_reentry", state, 1);
    push(K_WR, 0, 4);
    keypad = 10'd1 << 4;
    cyc(1);
    chk("t6_first_idx", {wr_en, wr_idx}, 8);
    keypad = '0;
    cyc(2);
    chk("sb_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
